// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_EVEN,
    PARITY_ODD
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic int unsigned baud_period(input int unsigned clk_hz,
                                              input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Ready/valid word handshake between a producer and the UART transmitter.
interface uart_tx_cfg_if #(
  parameter int unsigned DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_data_valid;
  logic                 tx_ready;

  modport master (
    output tx_data,
    output tx_data_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_data_valid,
    output tx_ready
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter; tick marks the last cycle of each bit, restart realigns to a frame.
module uart_baud_gen #(
  parameter int unsigned PERIOD = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(PERIOD - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    // Registered tick lines up with the cycle the counter sits at its terminal value.
    tick_d = (cnt_d == CW'(PERIOD - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: holding register, framing FSM, shift register and parity.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 12000000,
  parameter int unsigned BAUD_RATE   = 9600,
  parameter int unsigned DATA_BITS   = 8,
  parameter parity_t     PARITY      = PARITY_NONE,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  uart_tx_cfg_if.slave bus,
  output logic         tx,
  output logic         transmitting
);

  localparam int unsigned BAUD_PERIOD = baud_period(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned BCW         = $clog2(DATA_BITS + 1);
  localparam bit          PAR_EN      = (PARITY != PARITY_NONE);

  if (BAUD_PERIOD < 2) begin : g_bad_baud
    $error("uart_tx_cfg: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  tx_state_t            state_q, state_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 par_q, par_d;
  logic                 ready_q, ready_d;
  logic                 tx_q, tx_d;
  logic                 trans_q, trans_d;
  logic                 accept;
  logic                 load;
  logic                 tick;

  uart_baud_gen #(
    .PERIOD (BAUD_PERIOD)
  ) u_baud_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (load),
    .tick    (tick)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load        = 1'b0;
    accept      = bus.tx_data_valid && ready_q;

    unique case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          load = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
            state_d   = PAR_EN ? uart_pkg::PARITY : STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      uart_pkg::PARITY: begin
        if (tick) begin
          state_d   = STOP;
          bit_cnt_d = '0;
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_cnt_q == BCW'(STOP_BITS - 1)) begin
            bit_cnt_d = '0;
            if (hold_full_q) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Entering START always takes the held word; the parity bit is fixed at load time.
    if (load) begin
      state_d     = START;
      bit_cnt_d   = '0;
      shift_d     = hold_q;
      par_d       = (PARITY == PARITY_ODD) ? ~^hold_q : ^hold_q;
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end
    ready_d = !hold_full_d;

    unique case (state_d)
      IDLE:             tx_d = 1'b1;
      START:            tx_d = 1'b0;
      DATA:             tx_d = shift_d[0];
      uart_pkg::PARITY: tx_d = par_d;
      STOP:             tx_d = 1'b1;
      default:          tx_d = 1'b1;
    endcase
    trans_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      par_q       <= 1'b0;
      ready_q     <= 1'b1;
      tx_q        <= 1'b1;
      trans_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      par_q       <= par_d;
      ready_q     <= ready_d;
      tx_q        <= tx_d;
      trans_q     <= trans_d;
    end
  end

  assign bus.tx_ready = ready_q;
  assign tx           = tx_q;
  assign transmitting = trans_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: four configurations at BAUD_PERIOD = 16.
module tb_uart_tx_cfg;
  import uart_pkg::*;

  localparam int BP = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [3:0] valid_r;
  logic [8:0] data_r [4];
  wire  [3:0] tx_w, trans_w, ready_w;

  uart_tx_cfg_if #(.DATA_BITS(8)) if8 ();
  uart_tx_cfg_if #(.DATA_BITS(7)) if7 ();
  uart_tx_cfg_if #(.DATA_BITS(9)) if9 ();
  uart_tx_cfg_if #(.DATA_BITS(5)) if5 ();

  assign if8.tx_data = data_r[0][7:0];
  assign if7.tx_data = data_r[1][6:0];
  assign if9.tx_data = data_r[2][8:0];
  assign if5.tx_data = data_r[3][4:0];
  assign if8.tx_data_valid = valid_r[0];
  assign if7.tx_data_valid = valid_r[1];
  assign if9.tx_data_valid = valid_r[2];
  assign if5.tx_data_valid = valid_r[3];
  assign ready_w = {if5.tx_ready, if9.tx_ready, if7.tx_ready, if8.tx_ready};

  uart_tx_cfg #(.CLK_FREQ_HZ(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(1))
    u8 (.clk(clk), .rst_n(rst_n), .bus(if8), .tx(tx_w[0]), .transmitting(trans_w[0]));
  uart_tx_cfg #(.CLK_FREQ_HZ(16), .BAUD_RATE(1), .DATA_BITS(7), .PARITY(PARITY_EVEN), .STOP_BITS(2))
    u7 (.clk(clk), .rst_n(rst_n), .bus(if7), .tx(tx_w[1]), .transmitting(trans_w[1]));
  uart_tx_cfg #(.CLK_FREQ_HZ(16), .BAUD_RATE(1), .DATA_BITS(9), .PARITY(PARITY_ODD), .STOP_BITS(1))
    u9 (.clk(clk), .rst_n(rst_n), .bus(if9), .tx(tx_w[2]), .transmitting(trans_w[2]));
  uart_tx_cfg #(.CLK_FREQ_HZ(16), .BAUD_RATE(1), .DATA_BITS(5), .PARITY(PARITY_NONE), .STOP_BITS(1))
    u5 (.clk(clk), .rst_n(rst_n), .bus(if5), .tx(tx_w[3]), .transmitting(trans_w[3]));

  task automatic wait_ready(input int d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (ready_w[d] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    valid_r = '0;
    for (int i = 0; i < 4; i++) data_r[i] = '0;
    repeat (3) @(negedge clk);
    tests++; if (tx_w !== 4'hF) begin fails++; $display("FAIL reset_tx: got %b want 1111", tx_w); end
    tests++; if (trans_w !== 4'h0) begin fails++; $display("FAIL reset_transmitting: got %b want 0000", trans_w); end
    tests++; if (ready_w !== 4'hF) begin fails++; $display("FAIL reset_ready: got %b want 1111", ready_w); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // par < 0 means no parity bit; otherwise par is the hand-computed parity level.
  task automatic test_frame(input int d, input logic [8:0] data, input int nbits, input int par,
                            input int stops, input int exp_len, input string name);
    logic eb [16];
    int   nb, len, bad;
    logic got;
    bit   ok;
    eb[0] = 1'b0;
    for (int i = 0; i < nbits; i++) eb[1 + i] = data[i];
    nb = 1 + nbits;
    if (par >= 0) begin eb[nb] = 1'(par); nb++; end
    for (int s = 0; s < stops; s++) begin eb[nb] = 1'b1; nb++; end

    wait_ready(d, ok);
    if (!ok) begin
      tests++; fails++;
      $display("FAIL %s_ready: tx_ready got %b want 1 within 400 cycles", name, ready_w[d]);
      return;
    end
    data_r[d]  = data;
    valid_r[d] = 1'b1;
    @(negedge clk);
    valid_r[d] = 1'b0;
    @(negedge clk);
    len = 0;
    for (int b = 0; b < nb; b++) begin
      bad = 0;
      got = eb[b];
      for (int c = 0; c < BP; c++) begin
        if (trans_w[d] === 1'b1) len++;
        if (tx_w[d] !== eb[b]) begin bad++; got = tx_w[d]; end
        @(negedge clk);
      end
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL %s_bit%0d: line got %b in %0d of 16 cycles, want %b", name, b, got, bad, eb[b]);
      end
    end
    while (trans_w[d] === 1'b1 && len < exp_len + 64) begin
      len++;
      @(negedge clk);
    end
    tests++; if (len != exp_len) begin fails++; $display("FAIL %s_length: got %0d want %0d", name, len, exp_len); end
    tests++; if (tx_w[d] !== 1'b1) begin fails++; $display("FAIL %s_idle: tx got %b want 1", name, tx_w[d]); end
  endtask

  task automatic test_8n1();
    test_frame(0, 9'h0A5, 8, -1, 1, 160, "8n1_a5");
  endtask

  task automatic test_even_parity();
    test_frame(1, 9'h053, 7, 0, 2, 176, "7e2_53");
    test_frame(1, 9'h051, 7, 1, 2, 176, "7e2_51");
  endtask

  task automatic test_odd_parity();
    test_frame(2, 9'h1FF, 9, 0, 1, 192, "9o1_1ff");
    test_frame(3, 9'h01F, 5, -1, 1, 112, "5n1_1f");
  endtask

  // Three words through the 8N1 instance with valid held; junk scrambles tx_data while not ready.
  task automatic run_stream(input bit junk, input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input string name);
    logic [7:0] w [3];
    logic rec_tx [520];
    logic rec_tr [520];
    logic exp_bit;
    int idx, acc, n, bad;
    bit pend;
    w = '{w0, w1, w2};
    idx = 0; acc = 0; n = 0; pend = 1'b0;
    data_r[0]  = {1'b0, w0};
    valid_r[0] = 1'b1;
    for (int cyc = 0; cyc < 700; cyc++) begin
      if ((n > 0 || trans_w[0] === 1'b1) && n < 520) begin
        rec_tx[n] = tx_w[0];
        rec_tr[n] = trans_w[0];
        n++;
      end
      if (pend) begin
        pend = 1'b0;
        tests++;
        if (ready_w[0] !== 1'b0) begin
          fails++;
          $display("FAIL %s_ready_low%0d: tx_ready got %b want 0", name, idx, ready_w[0]);
        end
        idx++;
        if (idx >= 3) valid_r[0] = 1'b0;
      end
      if (valid_r[0]) begin
        if (ready_w[0] === 1'b1) begin
          data_r[0] = {1'b0, w[idx]};
          pend = 1'b1;
          acc++;
        end else if (junk) begin
          data_r[0] = 9'($urandom);
        end
      end
      @(negedge clk);
    end
    valid_r[0] = 1'b0;
    tests++; if (acc != 3) begin fails++; $display("FAIL %s_accepts: got %0d want 3", name, acc); end
    for (int f = 0; f < 3; f++) begin
      bad = 0;
      for (int i = 0; i < 10 * BP; i++) begin
        int k, b;
        k = f * 10 * BP + i;
        b = i / BP;
        exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : w[f][b - 1];
        if (k >= n || rec_tx[k] !== exp_bit || rec_tr[k] !== 1'b1) bad++;
      end
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL %s_frame%0d: %0d of 160 cycles wrong, want word %h contiguous", name, f, bad, w[f]);
      end
    end
    tests++;
    if (n < 481 || rec_tr[480] !== 1'b0 || rec_tx[480] !== 1'b1) begin
      fails++;
      $display("FAIL %s_end: recorded %0d cycles, want transmitting 0 and tx 1 at cycle 480", name, n);
    end
  endtask

  task automatic test_back_to_back();
    run_stream(1'b0, 8'h11, 8'h22, 8'h33, "b2b");
  endtask

  task automatic test_backpressure();
    run_stream(1'b1, 8'h3C, 8'h5A, 8'hC3, "bp");
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int bad;
    wait_ready(0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL rst_mid_ready: tx_ready got %b want 1", ready_w[0]); end
    data_r[0]  = 9'h0A5;
    valid_r[0] = 1'b1;
    @(negedge clk);
    valid_r[0] = 1'b0;
    @(negedge clk);
    data_r[0]  = 9'h03C;
    valid_r[0] = 1'b1;
    @(negedge clk);
    valid_r[0] = 1'b0;
    repeat (39) @(negedge clk);
    tests++; if (trans_w[0] !== 1'b1) begin fails++; $display("FAIL rst_mid_active: transmitting got %b want 1", trans_w[0]); end
    tests++; if (ready_w[0] !== 1'b0) begin fails++; $display("FAIL rst_mid_held: tx_ready got %b want 0", ready_w[0]); end
    #1 rst_n = 1'b0;
    #1;
    tests++; if (tx_w[0] !== 1'b1) begin fails++; $display("FAIL rst_mid_tx: got %b want 1", tx_w[0]); end
    tests++; if (trans_w[0] !== 1'b0) begin fails++; $display("FAIL rst_mid_transmitting: got %b want 0", trans_w[0]); end
    tests++; if (ready_w[0] !== 1'b1) begin fails++; $display("FAIL rst_mid_ready_high: got %b want 1", ready_w[0]); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || trans_w[0] !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL rst_mid_no_resume: line active in %0d of 250 cycles, want 0", bad);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_r = '0;
    test_reset();
    test_8n1();
    test_even_parity();
    test_odd_parity();
    test_back_to_back();
    test_backpressure();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
